// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared definitions for the PS/2 mouse packet decoder:
//   - state_t        : packet assembly states
//   - B0_*           : bit positions inside the first (status) byte of a packet
//   - SCREEN_*/CENTRE_* : playfield limits and power-up cursor position
//   - POS_W          : width of the cursor coordinate outputs
// -----------------------------------------------------------------------------
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  // Status byte layout
  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_M    = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XO   = 6;
  localparam int B0_YO   = 7;

  // 1024x768 playfield
  localparam int SCREEN_X_MAX = 1023;
  localparam int SCREEN_Y_MAX = 767;
  localparam int CENTRE_X     = 512;
  localparam int CENTRE_Y     = 384;

  localparam int POS_W = 12;

endpackage

// File: rtl/mouse_axis_clamp.sv
// -----------------------------------------------------------------------------
// mouse_axis_clamp
// Combinational next-position calculation for one cursor axis.
// Adds (or subtracts, when negate is set) a 9-bit two's-complement mouse delta
// to the current position and saturates the result to 0..MAX. When the
// overflow flag from the packet is set the axis simply holds its position.
//
// Parameters:
//   MAX       largest legal position on this axis
// Ports:
//   pos       in  12  current position
//   delta     in   9  signed movement from the packet
//   negate    in   1  subtract delta instead of adding it
//   overflow  in   1  packet overflow flag for this axis
//   next_pos  out 12  saturated next position
// -----------------------------------------------------------------------------
module mouse_axis_clamp
  import mouse_pkg::*;
#(
  parameter int MAX = SCREEN_X_MAX
) (
  input  logic [POS_W-1:0] pos,
  input  logic signed [8:0] delta,
  input  logic              negate,
  input  logic              overflow,
  output logic [POS_W-1:0] next_pos
);

  localparam logic signed [12:0] MAX_S = 13'(MAX);
  localparam logic [POS_W-1:0]    MAX_U = POS_W'(MAX);

  logic signed [12:0] pos_ext;
  logic signed [12:0] delta_ext;
  logic signed [12:0] sum;

  // 13 bits signed covers 0..1023 +/- 256 with room to spare, so the sum
  // never wraps before it is clamped.
  always_comb begin
    pos_ext   = {1'b0, pos};
    delta_ext = {{4{delta[8]}}, delta};
    if (negate) begin
      sum = pos_ext - delta_ext;
    end else begin
      sum = pos_ext + delta_ext;
    end

    if (overflow) begin
      next_pos = pos;
    end else if (sum[12]) begin
      next_pos = '0;
    end else if (sum > MAX_S) begin
      next_pos = MAX_U;
    end else begin
      next_pos = sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// -----------------------------------------------------------------------------
// mouse_packet_decoder
// Assembles the 3-byte PS/2 mouse packet stream into an absolute cursor
// position saturated to the playfield, plus button states. Feeds the
// board-drawing pipeline in the pclk domain.
//
// Build option:
//   MOUSE_SYNC_CHECK_EN  when defined, a first byte with bit3 = 0 is rejected
//                        (pkt_err pulse, stay waiting for the first byte) so
//                        the stream realigns after a dropped byte.
//
// Ports:
//   pclk          in   1  pixel clock
//   rst           in   1  asynchronous active-high reset
//   rx_data       in   8  byte from the PS/2 receiver
//   rx_valid      in   1  one-cycle strobe qualifying rx_data
//   xpos          out 12  cursor X, 0..X_MAX
//   ypos          out 12  cursor Y, 0..Y_MAX, downward positive
//   mouse_left    out  1  left button from the last complete packet
//   mouse_right   out  1  right button
//   mouse_middle  out  1  middle button
//   pkt_done      out  1  one-cycle pulse when the outputs update
//   pkt_err       out  1  one-cycle pulse on inter-byte timeout / sync reject
// -----------------------------------------------------------------------------
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int X_MAX       = SCREEN_X_MAX,
  parameter int Y_MAX       = SCREEN_Y_MAX,
  parameter int X_INIT      = CENTRE_X,
  parameter int Y_INIT      = CENTRE_Y,
  parameter int TIMEOUT_CYC = 130000,
  parameter int TO_W        = 18
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             mouse_left,
  output logic             mouse_right,
  output logic             mouse_middle,
  output logic             pkt_done,
  output logic             pkt_err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [7:0]       byte2_q, byte2_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [POS_W-1:0] xpos_q, xpos_d;
  logic [POS_W-1:0] ypos_q, ypos_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             middle_q, middle_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_err_q, pkt_err_d;

  logic [POS_W-1:0] x_next;
  logic [POS_W-1:0] y_next;
  logic             sync_ok;

  // Whether a byte arriving while waiting for the first byte may start a packet.
`ifdef MOUSE_SYNC_CHECK_EN
  assign sync_ok = rx_data[B0_SYNC];
`else
  assign sync_ok = 1'b1;
`endif

  // The sync bit carries no data; it only matters for the optional check above.
  logic unused_sync;
  assign unused_sync = byte0_q[B0_SYNC];

  // X moves with the PS/2 delta, Y is inverted because PS/2 Y is up-positive.
  mouse_axis_clamp #(.MAX(X_MAX)) u_clamp_x (
    .pos      (xpos_q),
    .delta    ({byte0_q[B0_XS], byte1_q}),
    .negate   (1'b0),
    .overflow (byte0_q[B0_XO]),
    .next_pos (x_next)
  );

  mouse_axis_clamp #(.MAX(Y_MAX)) u_clamp_y (
    .pos      (ypos_q),
    .delta    ({byte0_q[B0_YS], byte2_q}),
    .negate   (1'b1),
    .overflow (byte0_q[B0_YO]),
    .next_pos (y_next)
  );

  // Next-state logic. A byte that arrives in the same cycle the timeout
  // counter reaches its limit is accepted and no error is raised. UPDATE
  // commits the packet and can already accept the first byte of the next one.
  always_comb begin
    state_d    = state_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;
    to_cnt_d   = '0;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    left_d     = left_q;
    right_d    = right_q;
    middle_d   = middle_q;
    pkt_done_d = 1'b0;
    pkt_err_d  = 1'b0;

    case (state_q)
      WAIT_B0: begin
        if (rx_valid) begin
          if (sync_ok) begin
            byte0_d = rx_data;
            state_d = WAIT_B1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end

      WAIT_B1: begin
        if (rx_valid) begin
          byte1_d = rx_data;
          state_d = WAIT_B2;
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d   = WAIT_B0;
          pkt_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      WAIT_B2: begin
        if (rx_valid) begin
          byte2_d = rx_data;
          state_d = UPDATE;
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d   = WAIT_B0;
          pkt_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      UPDATE: begin
        xpos_d     = x_next;
        ypos_d     = y_next;
        left_d     = byte0_q[B0_L];
        right_d    = byte0_q[B0_R];
        middle_d   = byte0_q[B0_M];
        pkt_done_d = 1'b1;
        state_d    = WAIT_B0;
        if (rx_valid) begin
          if (sync_ok) begin
            byte0_d = rx_data;
            state_d = WAIT_B1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_B0;
      end
    endcase
  end

  // State and output registers; reset drops any partial packet at once.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_B0;
      byte0_q    <= '0;
      byte1_q    <= '0;
      byte2_q    <= '0;
      to_cnt_q   <= '0;
      xpos_q     <= POS_W'(X_INIT);
      ypos_q     <= POS_W'(Y_INIT);
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      middle_q   <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      to_cnt_q   <= to_cnt_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      left_q     <= left_d;
      right_q    <= right_d;
      middle_q   <= middle_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign mouse_left   = left_q;
  assign mouse_right  = right_q;
  assign mouse_middle = middle_q;
  assign pkt_done     = pkt_done_q;
  assign pkt_err      = pkt_err_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// -----------------------------------------------------------------------------
// tb_mouse_packet_decoder
// Self-checking bench for mouse_packet_decoder: a table of hand-computed
// packets, randomized packets against a plain-arithmetic cursor model, and
// hand-written sequences for timeout, reset, back-to-back and sync corners.
// The inter-byte timeout is shortened through the TIMEOUT_CYC parameter.
// -----------------------------------------------------------------------------
module tb_mouse_packet_decoder;

  localparam int TB_TIMEOUT = 200;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic        mouse_middle;
  logic        pkt_done;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int done_pulses = 0;

  typedef struct {
    bit         do_reset;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         x;
    int         y;
    bit         l;
    bit         r;
    bit         m;
  } vec_t;

  vec_t vecs[12];

  mouse_packet_decoder #(
    .TIMEOUT_CYC (TB_TIMEOUT),
    .TO_W        (18)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .xpos         (xpos),
    .ypos         (ypos),
    .mouse_left   (mouse_left),
    .mouse_right  (mouse_right),
    .mouse_middle (mouse_middle),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err)
  );

  always #5 pclk = ~pclk;

  // Count output pulses a little after each rising edge
  always @(posedge pclk) begin
    #2;
    if (pkt_err) err_pulses++;
    if (pkt_done) done_pulses++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one byte for one cycle; called and returns on a falling edge
  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int gap);
    sendByte(b0);
    idle(gap);
    sendByte(b1);
    idle(gap);
    sendByte(b2);
  endtask

  // Asynchronous reset: outputs must take reset values without a clock edge
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_xpos", int'(xpos), 512);
    checkOutput("rst_ypos", int'(ypos), 384);
    checkOutput("rst_buttons", int'({mouse_middle, mouse_right, mouse_left}), 0);
    checkOutput("rst_done", int'(pkt_done), 0);
    checkOutput("rst_err", int'(pkt_err), 0);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  function automatic int clampAxis(input int pos, input int d, input int maxv);
    int s;
    s = pos + d;
    if (s < 0) return 0;
    if (s > maxv) return maxv;
    return s;
  endfunction

  initial begin
    int mx;
    int my;
    int dx;
    int dy;
    int e0;
    int d0;
    int waited;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vecs[0]  = '{1'b1, 8'h09, 8'h10, 8'h00,  528, 384, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h38, 8'h00, 8'hF6,  256, 394, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h08, 8'hFF, 8'hFF,  767, 129, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h08, 8'hFD, 8'h7F, 1020,   2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h08, 8'h7F, 8'h14, 1023,   0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h18, 8'h00, 8'h00,  256, 384, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h18, 8'h00, 8'h00,    0, 384, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h18, 8'h00, 8'h00,    0, 384, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h49, 8'h20, 8'h05,  512, 379, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h0E, 8'h00, 8'h00,  512, 379, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h8A, 8'h05, 8'h05,  517, 379, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h28, 8'h00, 8'h80,  517, 507, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge pclk);
    doReset();

    // Table-driven packets
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2, i % 3);
      checkOutput("tbl_done_early", int'(pkt_done), 0);
      @(negedge pclk);
      checkOutput("tbl_done", int'(pkt_done), 1);
      checkOutput("tbl_xpos", int'(xpos), vecs[i].x);
      checkOutput("tbl_ypos", int'(ypos), vecs[i].y);
      checkOutput("tbl_left", int'(mouse_left), int'(vecs[i].l));
      checkOutput("tbl_right", int'(mouse_right), int'(vecs[i].r));
      checkOutput("tbl_middle", int'(mouse_middle), int'(vecs[i].m));
      @(negedge pclk);
      checkOutput("tbl_done_drop", int'(pkt_done), 0);
    end

    // Randomized packets against the cursor model
    doReset();
    mx = 512;
    my = 384;
    for (int i = 0; i < 60; i++) begin
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      applyStimulus(b0, b1, b2, $urandom_range(0, 3));
      @(negedge pclk);
      dx = int'(b1) - (b0[4] ? 256 : 0);
      dy = int'(b2) - (b0[5] ? 256 : 0);
      if (!b0[6]) mx = clampAxis(mx, dx, 1023);
      if (!b0[7]) my = clampAxis(my, -dy, 767);
      checkOutput("rnd_xpos", int'(xpos), mx);
      checkOutput("rnd_ypos", int'(ypos), my);
      checkOutput("rnd_buttons", int'({mouse_middle, mouse_right, mouse_left}), int'(b0[2:0]));
      idle($urandom_range(0, 2));
    end

    // Next packet's first byte arriving during the update cycle
    doReset();
    sendByte(8'h09);
    sendByte(8'h10);
    sendByte(8'h00);
    sendByte(8'h08);
    checkOutput("b2b_done", int'(pkt_done), 1);
    checkOutput("b2b_xpos1", int'(xpos), 528);
    sendByte(8'h01);
    sendByte(8'h00);
    @(negedge pclk);
    checkOutput("b2b_xpos2", int'(xpos), 529);
    checkOutput("b2b_left2", int'(mouse_left), 0);

    // Inter-byte timeout: error pulse, outputs untouched, then recovery
    doReset();
    e0 = err_pulses;
    d0 = done_pulses;
    sendByte(8'h08);
    sendByte(8'h10);
    waited = 0;
    while (err_pulses == e0 && waited < TB_TIMEOUT * 3) begin
      @(negedge pclk);
      waited++;
    end
    checkOutput("to_err_seen", err_pulses - e0, 1);
    checkOutput("to_err_delay", waited, TB_TIMEOUT + 1);
    checkOutput("to_xpos", int'(xpos), 512);
    checkOutput("to_ypos", int'(ypos), 384);
    checkOutput("to_no_done", done_pulses - d0, 0);
    @(negedge pclk);
    checkOutput("to_err_drop", int'(pkt_err), 0);
    applyStimulus(8'h08, 8'h01, 8'h00, 0);
    @(negedge pclk);
    checkOutput("to_recover_xpos", int'(xpos), 513);

    // Byte arriving exactly when the counter hits the limit wins
    doReset();
    e0 = err_pulses;
    sendByte(8'h09);
    idle(TB_TIMEOUT);
    sendByte(8'h10);
    idle(TB_TIMEOUT);
    sendByte(8'h00);
    @(negedge pclk);
    checkOutput("to_edge_xpos", int'(xpos), 528);
    checkOutput("to_edge_left", int'(mouse_left), 1);
    checkOutput("to_edge_no_err", err_pulses - e0, 0);

    // Reset in the middle of a packet
    doReset();
    applyStimulus(8'h09, 8'h10, 8'h00, 0);
    @(negedge pclk);
    checkOutput("mid_pre_xpos", int'(xpos), 528);
    sendByte(8'h08);
    sendByte(8'h10);
    doReset();
    applyStimulus(8'h08, 8'h01, 8'h00, 0);
    @(negedge pclk);
    checkOutput("mid_post_xpos", int'(xpos), 513);
    checkOutput("mid_post_ypos", int'(ypos), 384);

    // Misaligned stream
    doReset();
    e0 = err_pulses;
`ifdef MOUSE_SYNC_CHECK_EN
    sendByte(8'h10);
    sendByte(8'h08);
    sendByte(8'h04);
    sendByte(8'h00);
    @(negedge pclk);
    checkOutput("sync_xpos", int'(xpos), 516);
    checkOutput("sync_ypos", int'(ypos), 384);
    checkOutput("sync_err", err_pulses - e0, 1);
`else
    sendByte(8'h10);
    sendByte(8'h08);
    sendByte(8'h04);
    sendByte(8'h00);
    checkOutput("nosync_xpos", int'(xpos), 264);
    checkOutput("nosync_ypos", int'(ypos), 380);
    checkOutput("nosync_err", err_pulses - e0, 0);
    sendByte(8'h00);
    sendByte(8'h00);
    @(negedge pclk);
    checkOutput("nosync_next_xpos", int'(xpos), 264);
    checkOutput("nosync_next_ypos", int'(ypos), 380);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
